// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: default widths, opcode encodings
// and the bit layout of the {n,z,c,v} flag nibble.
package alu_pkg;

  localparam int ALU_OPSIZE = 4;
  localparam int ALU_DSIZE  = 16;
  localparam int ALU_NREGS  = 8;
  localparam int ALU_ASIZE  = 3;

  localparam logic [3:0] OP_PASSA = 4'b0000;
  localparam logic [3:0] OP_INC   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0011;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_PASSB = 4'b0110;
  localparam logic [3:0] OP_DEC   = 4'b0111;
  localparam logic [3:0] OP_AND   = 4'b1000;
  localparam logic [3:0] OP_OR    = 4'b1001;
  localparam logic [3:0] OP_XOR   = 4'b1010;
  localparam logic [3:0] OP_NOT   = 4'b1011;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f        = '0;
    f[FLG_N] = n;
    f[FLG_Z] = z;
    f[FLG_C] = c;
    f[FLG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREGS x DSIZE register file: one synchronous write port, two asynchronous
// read ports, every entry cleared by the synchronous active-low reset.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DSIZE = ALU_DSIZE,
  parameter int NREGS = ALU_NREGS,
  parameter int ASIZE = ALU_ASIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr_a,
  output logic [DSIZE-1:0] rdata_a,
  input  logic [ASIZE-1:0] raddr_b,
  output logic [DSIZE-1:0] rdata_b
);

  logic [DSIZE-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand/issue stage for the 16-bit ALU: E stage holds registered ALU operands,
// R stage holds the result until downstream takes it; E->A forwarding of alu_f.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int OPSIZE = ALU_OPSIZE,
  parameter int DSIZE  = ALU_DSIZE,
  parameter int NREGS  = ALU_NREGS,
  parameter int ASIZE  = ALU_ASIZE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OPSIZE-1:0] cmd_op,
  input  logic [ASIZE-1:0]  cmd_ra,
  input  logic [ASIZE-1:0]  cmd_rb,
  input  logic [ASIZE-1:0]  cmd_rd,
  input  logic              cmd_imm_sel,
  input  logic [DSIZE-1:0]  cmd_imm,
  output logic [OPSIZE-1:0] alu_op,
  output logic [DSIZE-1:0]  alu_a,
  output logic [DSIZE-1:0]  alu_b,
  input  logic [DSIZE-1:0]  alu_f,
  input  logic              alu_n,
  input  logic              alu_c,
  input  logic              alu_v,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DSIZE-1:0]  res_data,
  output logic [ASIZE-1:0]  res_rd,
  output logic [3:0]        res_flags
);

  logic             e_valid;
  logic [ASIZE-1:0] e_rd;
  logic             adv_e;
  logic             accept;
  logic [DSIZE-1:0] rf_a;
  logic [DSIZE-1:0] rf_b;
  logic [DSIZE-1:0] fwd_a;
  logic [DSIZE-1:0] fwd_b;

  assign adv_e     = e_valid && (!res_valid || res_ready);
  assign cmd_ready = !e_valid || adv_e;
  assign accept    = cmd_valid && cmd_ready;

  // The result leaving E this edge is not yet in the regfile, so bypass it.
  assign fwd_a = (adv_e && (e_rd == cmd_ra)) ? alu_f : rf_a;
  assign fwd_b = (adv_e && (e_rd == cmd_rb)) ? alu_f : rf_b;

  alu_regfile #(
    .DSIZE (DSIZE),
    .NREGS (NREGS),
    .ASIZE (ASIZE)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (adv_e),
    .waddr   (e_rd),
    .wdata   (alu_f),
    .raddr_a (cmd_ra),
    .rdata_a (rf_a),
    .raddr_b (cmd_rb),
    .rdata_b (rf_b)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_valid <= 1'b0;
      e_rd    <= '0;
      alu_op  <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
    end else if (accept) begin
      e_valid <= 1'b1;
      e_rd    <= cmd_rd;
      alu_op  <= cmd_op;
      alu_a   <= fwd_a;
      alu_b   <= cmd_imm_sel ? cmd_imm : fwd_b;
    end else if (adv_e) begin
      e_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_rd    <= '0;
      res_flags <= '0;
    end else if (adv_e) begin
      res_valid <= 1'b1;
      res_data  <= alu_f;
      res_rd    <= e_rd;
      res_flags <= pack_flags(alu_n, alu_f == '0, alu_c, alu_v);
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

  // A stalled result must hold its payload until downstream takes it.
  a_res_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (res_valid && !res_ready) |=> (res_valid && $stable(res_data) &&
                                   $stable(res_rd) && $stable(res_flags)));

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed and randomized checks of alu_issue_stage driving a behavioural ALU,
// scored against an in-order sequential execution model of the command stream.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [2:0]  cmd_ra, cmd_rb, cmd_rd;
  logic        cmd_imm_sel;
  logic [15:0] cmd_imm;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_f;
  logic        alu_n, alu_c, alu_v;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [2:0]  res_rd;
  logic [3:0]  res_flags;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
    .cmd_imm_sel(cmd_imm_sel), .cmd_imm(cmd_imm),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_f(alu_f), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_rd(res_rd), .res_flags(res_flags)
  );

  // Behavioural ALU: returns {n, c, v, f}.
  function automatic logic [18:0] alu_eval(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] f;
    logic        n, c, v;
    s = '0; f = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_PASSA: f = a;
      OP_INC:   begin s = {1'b0, a} + 17'd1; f = s[15:0]; c = s[16]; v = (a == 16'h7FFF); end
      OP_SUB:   begin s = {1'b0, a} - {1'b0, b}; f = s[15:0]; c = s[16];
                      v = (a[15] != b[15]) && (f[15] != a[15]); end
      OP_ADD:   begin s = {1'b0, a} + {1'b0, b}; f = s[15:0]; c = s[16];
                      v = (a[15] == b[15]) && (f[15] != a[15]); end
      OP_PASSB: f = b;
      OP_DEC:   begin s = {1'b0, a} - 17'd1; f = s[15:0]; c = s[16]; v = (a == 16'h8000); end
      OP_AND:   f = a & b;
      OP_OR:    f = a | b;
      OP_XOR:   f = a ^ b;
      OP_NOT:   f = ~a;
      default:  f = '0;
    endcase
    n = op[3] ? 1'b0 : f[15];
    return {n, c, v, f};
  endfunction

  always_comb {alu_n, alu_c, alu_v, alu_f} = alu_eval(alu_op, alu_a, alu_b);

  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  rd;
    logic [3:0]  fl;
    logic [31:0] cyc;
  } res_t;

  logic [15:0] mregs [8];
  res_t        exp_q[$];
  res_t        obs_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic        acc_now, xfer_now;

  // Commands execute strictly in order against an architectural register array.
  task automatic model_accept();
    logic [15:0] a, b;
    logic [18:0] r;
    res_t        e;
    a = mregs[cmd_ra];
    b = cmd_imm_sel ? cmd_imm : mregs[cmd_rb];
    r = alu_eval(cmd_op, a, b);
    e.d = r[15:0]; e.rd = cmd_rd; e.cyc = '0;
    e.fl = {r[18], (r[15:0] == 16'h0), r[17], r[16]};
    mregs[cmd_rd] = r[15:0];
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    exp_q.delete();
    obs_q.delete();
  endtask

  // Observe handshakes on the falling edge, then advance one rising edge.
  task automatic step();
    res_t o;
    @(negedge clk);
    acc_now = 1'b0;
    xfer_now = 1'b0;
    if (rst_n === 1'b1 && cmd_valid && cmd_ready === 1'b1) begin
      acc_now = 1'b1;
      model_accept();
    end
    if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready) begin
      xfer_now = 1'b1;
      o.d = res_data; o.rd = res_rd; o.fl = res_flags; o.cyc = cyc;
      obs_q.push_back(o);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_cmd(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                         input logic [2:0] rd, input logic sel, input logic [15:0] imm);
    cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd; cmd_imm_sel = sel; cmd_imm = imm;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; res_ready = 1'b1; cmd_valid = 1'b1;
    set_cmd(OP_ADD, 3'd1, 3'd2, 3'd3, 1'b1, 16'hABCD);
    step(); step();
    checks++;
    if ({cmd_ready, res_valid} !== 2'b10)
      begin errors++; $display("FAIL reset_hs {cmd_ready,res_valid}=%b want 10", {cmd_ready, res_valid}); end
    checks++;
    if ({alu_op, alu_a, alu_b, res_data, res_rd, res_flags} !== '0)
      begin errors++; $display("FAIL reset_outs op=%h a=%h b=%h d=%h rd=%h fl=%b want all 0",
                               alu_op, alu_a, alu_b, res_data, res_rd, res_flags); end
    model_reset();
    rst_n = 1'b1;
    set_cmd(OP_PASSA, 3'd5, 3'd0, 3'd5, 1'b0, 16'h0);
    step();
    cmd_valid = 1'b0;
    for (int k = 0; k < 10 && obs_q.size() < 1; k++) step();
    checks++;
    if (obs_q.size() != 1)
      begin errors++; $display("FAIL reset_read count=%0d want 1", obs_q.size()); end
    else begin
      checks++;
      if (obs_q[0].d !== 16'h0000 || obs_q[0].fl !== 4'b0100 || obs_q[0].rd !== 3'd5)
        begin errors++; $display("FAIL reset_read d=%h fl=%b rd=%0d want 0000 0100 5",
                                 obs_q[0].d, obs_q[0].fl, obs_q[0].rd); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_imm_forwarding();
    logic [15:0] want_d [4];
    logic [2:0]  want_rd [4];
    want_d  = '{16'h0005, 16'h0003, 16'h0008, 16'h0010};
    want_rd = '{3'd1, 3'd2, 3'd3, 3'd3};
    res_ready = 1'b1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: set_cmd(OP_PASSB, 3'd0, 3'd0, 3'd1, 1'b1, 16'h0005);
        1: set_cmd(OP_PASSB, 3'd0, 3'd0, 3'd2, 1'b1, 16'h0003);
        2: set_cmd(OP_ADD,   3'd1, 3'd2, 3'd3, 1'b0, 16'h0000);
        default: set_cmd(OP_ADD, 3'd3, 3'd3, 3'd3, 1'b0, 16'h0000);
      endcase
      step();
      checks++;
      if (acc_now !== 1'b1)
        begin errors++; $display("FAIL imm_fwd_accept cmd=%0d accepted=%b want 1", i, acc_now); end
    end
    cmd_valid = 1'b0;
    for (int k = 0; k < 10 && obs_q.size() < 4; k++) step();
    checks++;
    if (obs_q.size() != 4)
      begin errors++; $display("FAIL imm_fwd_count got=%0d want 4", obs_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_q[i].d !== want_d[i] || obs_q[i].rd !== want_rd[i] || obs_q[i].fl !== exp_q[i].fl)
          begin errors++; $display("FAIL imm_fwd_res%0d d=%h rd=%0d fl=%b want %h %0d %b", i,
                                   obs_q[i].d, obs_q[i].rd, obs_q[i].fl, want_d[i], want_rd[i], exp_q[i].fl); end
        if (i > 0) begin
          checks++;
          if (obs_q[i].cyc != obs_q[i-1].cyc + 1)
            begin errors++; $display("FAIL imm_fwd_gap%0d cycle=%0d want %0d", i,
                                     obs_q[i].cyc, obs_q[i-1].cyc + 1); end
        end
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [15:0] want_d [3];
    logic [15:0] snap;
    int          idx;
    want_d = '{16'h1111, 16'h2222, 16'h2221};
    idx = 0; snap = '0;
    res_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cmd_valid = (idx < 3);
      case (idx)
        0: set_cmd(OP_PASSB, 3'd0, 3'd0, 3'd6, 1'b1, 16'h1111);
        1: set_cmd(OP_ADD,   3'd6, 3'd6, 3'd7, 1'b0, 16'h0000);
        default: set_cmd(OP_SUB, 3'd7, 3'd0, 3'd0, 1'b1, 16'h0001);
      endcase
      step();
      if (acc_now) idx++;
      if (k == 2) snap = res_data;
    end
    checks++;
    if (idx != 2 || cmd_ready !== 1'b0 || res_valid !== 1'b1)
      begin errors++; $display("FAIL bp_stall accepted=%0d cmd_ready=%b res_valid=%b want 2 0 1",
                               idx, cmd_ready, res_valid); end
    checks++;
    if (res_data !== snap || res_data !== 16'h1111)
      begin errors++; $display("FAIL bp_stable res_data=%h earlier=%h want 1111", res_data, snap); end
    res_ready = 1'b1;
    for (int k = 0; k < 20 && (obs_q.size() < 3 || idx < 3); k++) begin
      cmd_valid = (idx < 3);
      step();
      if (acc_now) idx++;
    end
    cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (obs_q.size() != 3)
      begin errors++; $display("FAIL bp_drain_count got=%0d want 3", obs_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_q[i].d !== want_d[i] || obs_q[i] [34:0] !== exp_q[i][34:0] - 0 && obs_q[i].rd !== exp_q[i].rd)
          begin errors++; $display("FAIL bp_drain%0d d=%h rd=%0d want %h %0d", i,
                                   obs_q[i].d, obs_q[i].rd, want_d[i], exp_q[i].rd); end
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_logic_zero();
    res_ready = 1'b1;
    cmd_valid = 1'b1;
    set_cmd(OP_PASSB, 3'd0, 3'd0, 3'd1, 1'b1, 16'h00F0);
    step();
    set_cmd(OP_XOR, 3'd1, 3'd0, 3'd4, 1'b1, 16'h00F0);
    step();
    cmd_valid = 1'b0;
    for (int k = 0; k < 10 && obs_q.size() < 2; k++) step();
    checks++;
    if (obs_q.size() != 2)
      begin errors++; $display("FAIL logic_zero_count got=%0d want 2", obs_q.size()); end
    else begin
      checks++;
      if (obs_q[1].d !== 16'h0000 || obs_q[1].fl !== 4'b0100 || obs_q[1].rd !== 3'd4)
        begin errors++; $display("FAIL logic_zero d=%h fl=%b rd=%0d want 0000 0100 4",
                                 obs_q[1].d, obs_q[1].fl, obs_q[1].rd); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_mid_reset();
    res_ready = 1'b0;
    cmd_valid = 1'b1;
    set_cmd(OP_PASSB, 3'd0, 3'd0, 3'd2, 1'b1, 16'h7777);
    step();
    set_cmd(OP_INC, 3'd6, 3'd0, 3'd1, 1'b0, 16'h0);
    step();
    cmd_valid = 1'b0;
    checks++;
    if (res_valid !== 1'b1 || cmd_ready !== 1'b0)
      begin errors++; $display("FAIL midrst_full res_valid=%b cmd_ready=%b want 1 0", res_valid, cmd_ready); end
    rst_n = 1'b0;
    step();
    model_reset();
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1)
      begin errors++; $display("FAIL midrst_clear res_valid=%b cmd_ready=%b want 0 1", res_valid, cmd_ready); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dut.u_rf.regs[i] !== 16'h0)
        begin errors++; $display("FAIL midrst_reg r%0d=%h want 0000", i, dut.u_rf.regs[i]); end
    end
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (obs_q.size() != 0)
      begin errors++; $display("FAIL midrst_ghost results=%0d want 0", obs_q.size()); end
    cmd_valid = 1'b1;
    set_cmd(OP_PASSA, 3'd6, 3'd0, 3'd0, 1'b0, 16'h0);
    step();
    cmd_valid = 1'b0;
    for (int k = 0; k < 10 && obs_q.size() < 1; k++) step();
    checks++;
    if (obs_q.size() != 1 || obs_q[0].d !== 16'h0000)
      begin errors++; $display("FAIL midrst_r6 count=%0d d=%h want 1 0000", obs_q.size(),
                               (obs_q.size() > 0) ? obs_q[0].d : 16'hxxxx); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [3:0] ops [10];
    ops = '{OP_PASSA, OP_INC, OP_SUB, OP_ADD, OP_PASSB, OP_DEC, OP_AND, OP_OR, OP_XOR, OP_NOT};
    for (int k = 0; k < 400; k++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      res_ready = ($urandom_range(0, 3) != 0);
      set_cmd(ops[$urandom_range(0, 9)], 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom));
      step();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    for (int k = 0; k < 20 && obs_q.size() < exp_q.size(); k++) step();
    checks++;
    if (obs_q.size() != exp_q.size() || exp_q.size() < 100)
      begin errors++; $display("FAIL rand_count got=%0d want %0d", obs_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i].d !== exp_q[i].d || obs_q[i].rd !== exp_q[i].rd || obs_q[i].fl !== exp_q[i].fl)
          begin errors++; $display("FAIL rand_res%0d d=%h rd=%0d fl=%b want %h %0d %b", i,
                                   obs_q[i].d, obs_q[i].rd, obs_q[i].fl,
                                   exp_q[i].d, exp_q[i].rd, exp_q[i].fl); end
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b1;
    set_cmd(OP_PASSA, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0);
    model_reset();
    test_reset();
    test_imm_forwarding();
    test_backpressure();
    test_logic_zero();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
